eco32f_wb_arbiter: RTL and testbench
====================================

Name: eco32f_wb_arbiter

Overview:
Two-master to one-slave Wishbone arbiter. It shares the single external bus between the instruction fetch/icache refill port (ibus) and the load/store unit data port (dbus). Grants are locked for a whole Wishbone cycle, so cache-line refill bursts are never split. A per-grant watchdog ends hung transfers with an error.

Parameters:
ROUND_ROBIN, 0, tie-break policy: 0 = dbus always wins ties; 1 = the master granted last loses ties.
TIMEOUT_CYCLES, 255, stalled-beat watchdog limit in cycles (1..65535); 0 disables the watchdog.

Ports:
clk  in  1  clock
rst  in  1  reset; one clock domain; reset is synchronous and active-high
ibus_adr_i  in  32  fetch address
ibus_cyc_i  in  1  fetch cycle request
ibus_stb_i  in  1  fetch strobe
ibus_cti_i  in  3  fetch cycle type
ibus_bte_i  in  2  fetch burst type
ibus_ack_o  out  1  ack to fetch master
ibus_err_o  out  1  error to fetch master
dbus_adr_i  in  32  data address
dbus_cyc_i  in  1  data cycle request
dbus_stb_i  in  1  data strobe
dbus_sel_i  in  4  data byte selects
dbus_we_i  in  1  data write enable
dbus_cti_i  in  3  data cycle type
dbus_bte_i  in  2  data burst type
dbus_dat_i  in  32  data write data
dbus_ack_o  out  1  ack to data master
dbus_err_o  out  1  error to data master
wbm_adr_o  out  32  bus address
wbm_cyc_o  out  1  bus cycle
wbm_stb_o  out  1  bus strobe
wbm_sel_o  out  4  bus byte selects
wbm_we_o  out  1  bus write enable
wbm_cti_o  out  3  bus cycle type
wbm_bte_o  out  2  bus burst type
wbm_dat_o  out  32  bus write data
wbm_ack_i  in  1  slave ack
wbm_err_i  in  1  slave error

Behaviour:
- Read data is not routed through this block. Both masters take slave read data directly.
- State machine has three states: IDLE, GNT_I, GNT_D. The grant is registered. Bus outputs are a combinational mux of the granted master's signals, gated by the grant.
- Reset: state IDLE, watchdog count 0, last_grant = ibus. While in IDLE or in reset, all wbm_* controls are 0: cyc, stb, we, sel, cti, bte. adr/dat are don't-care. Both ack_o and err_o are 0.
- IDLE transitions (registered; one-cycle arbitration latency):
  - Only ibus_cyc_i high: go to GNT_I.
  - Only dbus_cyc_i high: go to GNT_D.
  - Both high: ROUND_ROBIN=0 picks GNT_D. ROUND_ROBIN=1 picks the master other than last_grant.
  - Entering a grant updates last_grant.
- While granted:
  - wbm_cyc_o/wbm_stb_o follow the owner's cyc_i/stb_i.
  - ibus grant drives wbm_we_o=0 and wbm_sel_o=4'hf.
  - cti/bte/adr/dat are passed unchanged from the owner.
- wbm_ack_i/wbm_err_i go only to the owner, gated with the owner's stb_i. The non-owner always sees ack_o=err_o=0.
- Grant release: when the owner's cyc_i is low, the next state is IDLE. A request from the other master is then granted one cycle later, giving a minimum one-cycle gap between owners. The grant is held while cyc_i stays high, even with stb_i low.
- Watchdog (16-bit count):
  - Clears on entering a grant, on any ack/err, and when the owner's stb_i is low.
  - Increments each granted cycle with owner stb_i high and no ack/err.
  - When the count equals TIMEOUT_CYCLES (nonzero), the owner's err_o pulses for 1 cycle, wbm_stb_o and wbm_cyc_o are forced 0 in that cycle, and the state returns to IDLE.
- Simultaneous wbm_ack_i and wbm_err_i: both are forwarded. The slave is responsible for not doing this.
- Reset mid-transfer: the next cycle is IDLE with all outputs at reset values, regardless of the masters' cyc_i.

Test Plan:
- ibus only, 8-beat burst (cti 010 x7 then 111, bte 10), slave acks every cycle -> wbm_cyc_o rises 1 cycle after ibus_cyc_i; 8 ibus_ack_o pulses; wbm_we_o=0, wbm_sel_o=f; dbus_ack_o stays 0.
- Both cyc_i rise in the same cycle, ROUND_ROBIN=0 -> dbus owns the bus (wbm_adr_o=dbus_adr_i=0x00001000, we=1, dat=0xdeadbeef). ibus is granted 2 cycles after dbus_cyc_i falls.
- ROUND_ROBIN=1, both masters continuously issue single-beat cycles (cyc drops after each ack) -> grant order d,i,d,i with one IDLE cycle between each.
- dbus_cyc_i rises in the 3rd beat of an ibus 8-beat burst -> all 8 beats complete on ibus with no dbus beat interleaved; dbus is granted after ibus_cyc_i drops.
- TIMEOUT_CYCLES=16, dbus read with no ack -> dbus_err_o pulses in the 17th granted stb cycle; wbm_cyc_o is 0 that cycle; state returns to IDLE; ibus_err_o stays 0.
- rst asserted in the 4th beat of an ibus burst -> next cycle wbm_cyc_o=0, both ack_o=0; after rst deasserts with ibus_cyc_i high, ibus is regranted 1 cycle later.

Source files
------------

// File: rtl/eco32f_wb_arbiter.sv
// eco32f_wb_arbiter: shares one Wishbone slave port between the fetch (ibus)
// and load/store (dbus) masters. A grant is held for the whole Wishbone cycle
// so refill bursts stay atomic; a per-grant watchdog errors out hung beats.
module eco32f_wb_arbiter #(
    parameter int unsigned ROUND_ROBIN    = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] ibus_adr_i,
    input  logic        ibus_cyc_i,
    input  logic        ibus_stb_i,
    input  logic [2:0]  ibus_cti_i,
    input  logic [1:0]  ibus_bte_i,
    output logic        ibus_ack_o,
    output logic        ibus_err_o,

    input  logic [31:0] dbus_adr_i,
    input  logic        dbus_cyc_i,
    input  logic        dbus_stb_i,
    input  logic [3:0]  dbus_sel_i,
    input  logic        dbus_we_i,
    input  logic [2:0]  dbus_cti_i,
    input  logic [1:0]  dbus_bte_i,
    input  logic [31:0] dbus_dat_i,
    output logic        dbus_ack_o,
    output logic        dbus_err_o,

    output logic [31:0] wbm_adr_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    localparam int unsigned      WDT_W     = 16;
    localparam logic [WDT_W-1:0] WDT_LIMIT = WDT_W'(TIMEOUT_CYCLES);
    localparam bit               WDT_EN    = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } state_t;

    state_t           r_state;
    logic [WDT_W-1:0] r_wdt;
    logic             r_last_d;   // 1 when dbus held the most recent grant

    logic w_gnt_i;
    logic w_gnt_d;
    logic w_own_cyc;
    logic w_own_stb;
    logic w_rsp;
    logic w_tmo;
    logic w_tie_d;

    // Grant decode; reset blanks the grant in the same cycle it is asserted.
    assign w_gnt_i   = (r_state == ST_GNT_I) && !rst;
    assign w_gnt_d   = (r_state == ST_GNT_D) && !rst;
    assign w_own_cyc = (w_gnt_i && ibus_cyc_i) || (w_gnt_d && dbus_cyc_i);
    assign w_own_stb = (w_gnt_i && ibus_stb_i) || (w_gnt_d && dbus_stb_i);
    assign w_rsp     = wbm_ack_i || wbm_err_i;
    assign w_tmo     = WDT_EN && w_own_stb && (r_wdt == WDT_LIMIT);
    assign w_tie_d   = (ROUND_ROBIN == 0) || !r_last_d;

    // Bus request mux; a watchdog expiry drops cyc/stb for its cycle.
    assign wbm_cyc_o = w_own_cyc && !w_tmo;
    assign wbm_stb_o = w_own_stb && !w_tmo;
    assign wbm_we_o  = w_gnt_d && dbus_we_i;
    assign wbm_sel_o = w_gnt_d ? dbus_sel_i : (w_gnt_i ? 4'hf : 4'h0);
    assign wbm_cti_o = w_gnt_d ? dbus_cti_i : (w_gnt_i ? ibus_cti_i : 3'h0);
    assign wbm_bte_o = w_gnt_d ? dbus_bte_i : (w_gnt_i ? ibus_bte_i : 2'h0);
    assign wbm_adr_o = w_gnt_d ? dbus_adr_i : (w_gnt_i ? ibus_adr_i : 32'h0);
    assign wbm_dat_o = w_gnt_d ? dbus_dat_i : 32'h0;

    // Response steering: only the owner with stb high sees the slave reply.
    assign ibus_ack_o = w_gnt_i && ibus_stb_i && wbm_ack_i && !w_tmo;
    assign ibus_err_o = w_gnt_i && ((ibus_stb_i && wbm_err_i) || w_tmo);
    assign dbus_ack_o = w_gnt_d && dbus_stb_i && wbm_ack_i && !w_tmo;
    assign dbus_err_o = w_gnt_d && ((dbus_stb_i && wbm_err_i) || w_tmo);

    // Grant FSM, last-grant tracking and stalled-beat watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_wdt    <= '0;
            r_last_d <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wdt <= '0;
                    if (dbus_cyc_i && (!ibus_cyc_i || w_tie_d)) begin
                        r_state  <= ST_GNT_D;
                        r_last_d <= 1'b1;
                    end else if (ibus_cyc_i) begin
                        r_state  <= ST_GNT_I;
                        r_last_d <= 1'b0;
                    end
                end
                ST_GNT_I, ST_GNT_D: begin
                    if (!w_own_cyc || w_tmo) begin
                        r_state <= ST_IDLE;
                        r_wdt   <= '0;
                    end else if (w_rsp || !w_own_stb) begin
                        r_wdt <= '0;
                    end else begin
                        r_wdt <= r_wdt + WDT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_wdt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eco32f_wb_arbiter.sv
// Scoreboard bench for eco32f_wb_arbiter. Two instances share the stimulus:
// instance A uses the fixed dbus-priority tie-break, instance B round-robin;
// both use a 16-cycle watchdog. Each directed step pushes the hand-derived
// expected bus/response values for one cycle; the monitor pops and compares.
module tb_eco32f_wb_arbiter;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        iack;
        logic        ierr;
        logic        dack;
        logic        derr;
    } obs_t;

    typedef struct {
        int   dut;
        int   tid;
        int   cn;
        obs_t v;
        obs_t m;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ibus_adr;
    logic        ibus_cyc, ibus_stb;
    logic [2:0]  ibus_cti;
    logic [1:0]  ibus_bte;
    logic [31:0] dbus_adr, dbus_dat;
    logic        dbus_cyc, dbus_stb, dbus_we;
    logic [3:0]  dbus_sel;
    logic [2:0]  dbus_cti;
    logic [1:0]  dbus_bte;
    logic        wbm_ack, wbm_err;

    logic        a_iack, a_ierr, a_dack, a_derr, a_cyc, a_stb, a_we;
    logic [3:0]  a_sel;
    logic [2:0]  a_cti;
    logic [1:0]  a_bte;
    logic [31:0] a_adr, a_dat;
    logic        b_iack, b_ierr, b_dack, b_derr, b_cyc, b_stb, b_we;
    logic [3:0]  b_sel;
    logic [2:0]  b_cti;
    logic [1:0]  b_bte;
    logic [31:0] b_adr, b_dat;

    obs_t a_obs, b_obs;
    assign a_obs = '{a_cyc, a_stb, a_we, a_sel, a_cti, a_bte, a_adr, a_dat,
                     a_iack, a_ierr, a_dack, a_derr};
    assign b_obs = '{b_cyc, b_stb, b_we, b_sel, b_cti, b_bte, b_adr, b_dat,
                     b_iack, b_ierr, b_dack, b_derr};

    eco32f_wb_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(16)) u_dut_a (
        .clk(clk), .rst(rst),
        .ibus_adr_i(ibus_adr), .ibus_cyc_i(ibus_cyc), .ibus_stb_i(ibus_stb),
        .ibus_cti_i(ibus_cti), .ibus_bte_i(ibus_bte),
        .ibus_ack_o(a_iack), .ibus_err_o(a_ierr),
        .dbus_adr_i(dbus_adr), .dbus_cyc_i(dbus_cyc), .dbus_stb_i(dbus_stb),
        .dbus_sel_i(dbus_sel), .dbus_we_i(dbus_we), .dbus_cti_i(dbus_cti),
        .dbus_bte_i(dbus_bte), .dbus_dat_i(dbus_dat),
        .dbus_ack_o(a_dack), .dbus_err_o(a_derr),
        .wbm_adr_o(a_adr), .wbm_cyc_o(a_cyc), .wbm_stb_o(a_stb),
        .wbm_sel_o(a_sel), .wbm_we_o(a_we), .wbm_cti_o(a_cti),
        .wbm_bte_o(a_bte), .wbm_dat_o(a_dat),
        .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err)
    );

    eco32f_wb_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(16)) u_dut_b (
        .clk(clk), .rst(rst),
        .ibus_adr_i(ibus_adr), .ibus_cyc_i(ibus_cyc), .ibus_stb_i(ibus_stb),
        .ibus_cti_i(ibus_cti), .ibus_bte_i(ibus_bte),
        .ibus_ack_o(b_iack), .ibus_err_o(b_ierr),
        .dbus_adr_i(dbus_adr), .dbus_cyc_i(dbus_cyc), .dbus_stb_i(dbus_stb),
        .dbus_sel_i(dbus_sel), .dbus_we_i(dbus_we), .dbus_cti_i(dbus_cti),
        .dbus_bte_i(dbus_bte), .dbus_dat_i(dbus_dat),
        .dbus_ack_o(b_dack), .dbus_err_o(b_derr),
        .wbm_adr_o(b_adr), .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb),
        .wbm_sel_o(b_sel), .wbm_we_o(b_we), .wbm_cti_o(b_cti),
        .wbm_bte_o(b_bte), .wbm_dat_o(b_dat),
        .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cur_dut = 0;
    int   tid = 0;
    int   cn  = 0;

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            obs_t act;
            e   = q.pop_front();
            act = (e.dut == 0) ? a_obs : b_obs;
            vectors++;
            if (((act ^ e.v) & e.m) != '0) begin
                miscompares++;
                $display("FAIL test%0d cycle%0d dut%0d: got %h expected %h (care %h)",
                         e.tid, e.cn, e.dut, act, e.v, e.m);
            end
        end
    end

    task automatic set_i(input logic cyc, input logic stb, input logic [2:0] cti,
                         input logic [1:0] bte, input logic [31:0] adr);
        ibus_cyc = cyc; ibus_stb = stb; ibus_cti = cti; ibus_bte = bte; ibus_adr = adr;
    endtask

    task automatic set_d(input logic cyc, input logic stb, input logic we,
                         input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        dbus_cyc = cyc; dbus_stb = stb; dbus_we = we; dbus_sel = sel;
        dbus_cti = 3'b000; dbus_bte = 2'b00; dbus_adr = adr; dbus_dat = dat;
    endtask

    task automatic slv(input logic ack, input logic err);
        wbm_ack = ack; wbm_err = err;
    endtask

    // who: 0 = no owner (bus controls 0), 1 = ibus owns, 2 = dbus owns.
    task automatic step(input int who, input logic kill, input logic ia, input logic ie,
                        input logic da, input logic de);
        exp_t r;
        r.dut = cur_dut; r.tid = tid; r.cn = cn;
        r.v = '0;
        r.m = '1;
        if (who == 1) begin
            r.v.cyc = ibus_cyc & ~kill; r.v.stb = ibus_stb & ~kill;
            r.v.we  = 1'b0;             r.v.sel = 4'hf;
            r.v.cti = ibus_cti;         r.v.bte = ibus_bte;
            r.v.adr = ibus_adr;         r.m.dat = '0;
        end else if (who == 2) begin
            r.v.cyc = dbus_cyc & ~kill; r.v.stb = dbus_stb & ~kill;
            r.v.we  = dbus_we;          r.v.sel = dbus_sel;
            r.v.cti = dbus_cti;         r.v.bte = dbus_bte;
            r.v.adr = dbus_adr;         r.v.dat = dbus_dat;
        end else begin
            r.m.adr = '0;
            r.m.dat = '0;
        end
        r.v.iack = ia; r.v.ierr = ie; r.v.dack = da; r.v.derr = de;
        q.push_back(r);
        cn++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int dut, input int t);
        cur_dut = dut; tid = t; cn = 0;
        set_i(1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
        set_d(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        slv(1'b0, 1'b0);
        rst = 1'b1;
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_i(1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
        set_d(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        slv(1'b0, 1'b0);
        @(posedge clk);
        #1;

        // T1: ibus-only 8-beat wrap burst, slave acks every beat.
        do_reset(0, 1);
        set_i(1'b1, 1'b1, 3'b010, 2'b10, 32'h0000_0100);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            set_i(1'b1, 1'b1, (k == 7) ? 3'b111 : 3'b010, 2'b10, 32'h0000_0100 + 32'(4 * k));
            slv(1'b1, 1'b0);
            step(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        set_i(1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
        slv(1'b0, 1'b0);
        step(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // T2: simultaneous request, fixed priority gives dbus; ibus then sees a slave error.
        do_reset(0, 2);
        set_i(1'b1, 1'b1, 3'b000, 2'b00, 32'h0000_0200);
        set_d(1'b1, 1'b1, 1'b1, 4'hf, 32'h0000_1000, 32'hdead_beef);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        slv(1'b1, 1'b0);
        step(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        set_d(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        slv(1'b0, 1'b0);
        step(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        slv(1'b0, 1'b1);
        step(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        set_i(1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
        slv(1'b0, 1'b0);
        step(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // T3: round-robin, both masters keep issuing single beats: d,i,d,i.
        do_reset(1, 3);
        set_i(1'b1, 1'b1, 3'b000, 2'b00, 32'h0000_0400);
        set_d(1'b1, 1'b1, 1'b0, 4'hf, 32'h0000_1004, 32'h0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 2; r++) begin
            slv(1'b1, 1'b0);
            step(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            set_d(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            slv(1'b0, 1'b0);
            step(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            set_d(1'b1, 1'b1, 1'b0, 4'hf, 32'h0000_1004, 32'h0);
            step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            slv(1'b1, 1'b0);
            step(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            set_i(1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
            if (r == 1) set_d(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            slv(1'b0, 1'b0);
            step(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (r == 0) set_i(1'b1, 1'b1, 3'b000, 2'b00, 32'h0000_0400);
            step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // T4: dbus requests during beat 3 of an ibus burst; burst stays whole.
        do_reset(0, 4);
        set_i(1'b1, 1'b1, 3'b010, 2'b10, 32'h0000_0800);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            set_i(1'b1, 1'b1, (k == 7) ? 3'b111 : 3'b010, 2'b10, 32'h0000_0800 + 32'(4 * k));
            if (k == 2) set_d(1'b1, 1'b1, 1'b0, 4'hf, 32'h0000_3000, 32'h0);
            slv(1'b1, 1'b0);
            step(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        set_i(1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
        slv(1'b0, 1'b0);
        step(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        slv(1'b1, 1'b0);
        step(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        set_d(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        slv(1'b0, 1'b0);
        step(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // T5: dbus read never acked; watchdog errors it in the 17th stb cycle.
        do_reset(0, 5);
        set_d(1'b1, 1'b1, 1'b0, 4'hf, 32'h0000_2000, 32'h0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) step(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_d(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // T6: reset during beat 4 of an ibus burst, then regrant.
        do_reset(0, 6);
        set_i(1'b1, 1'b1, 3'b010, 2'b10, 32'h0000_0500);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            set_i(1'b1, 1'b1, 3'b010, 2'b10, 32'h0000_0500 + 32'(4 * k));
            slv(1'b1, 1'b0);
            step(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        set_i(1'b1, 1'b1, 3'b010, 2'b10, 32'h0000_050c);
        rst = 1'b1;
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        slv(1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        slv(1'b1, 1'b0);
        step(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_i(1'b1, 1'b1, 3'b111, 2'b10, 32'h0000_0510);
        step(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_i(1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
        slv(1'b0, 1'b0);
        step(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 4 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected records left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
